vga_sync_core: RTL

- Generates VGA 640x480@60 timing and supplies pixel coordinates (x, y) to the downstream pixel generator, e.g. the square/pattern generator.
- Takes that generator's 12-bit colour back in and blanks it outside the visible area.
- Registers colour together with hsync/vsync so all three leave the block aligned to the same pixel tick and drive the VGA connector directly.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_core_pix_tick_gen.sv | 32 +++
 rtl/vga_sync_core.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the sync core and its pixel-side users.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

  typedef logic [11:0] rgb12_t;
  typedef logic [10:0] coord_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int CLK_DIV_DEF   = 4;

  function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_core_pix_tick_gen.sv
// Pixel-rate strobe: one clk high out of every CLK_DIV, first one CLK_DIV clks after reset.
// The strobe is the registered compare of the divider against its last value.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam int            DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_p_tick;
  logic          w_div_last;

  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else begin
      r_p_tick <= w_div_last;
      r_div    <= w_div_last ? '0 : r_div + DW'(1);
    end
  end

  assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_core.sv
// VGA raster timing: pixel/line counters, sync decode and the output register that
// keeps blanked colour, hsync and vsync aligned one pixel tick behind x/y.
module vga_sync_core
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic   w_p_tick;
  logic   w_h_last;
  logic   w_v_last;
  logic   w_video_on;
  logic   w_hs_active;
  logic   w_vs_active;

  coord_t r_h_cnt;
  coord_t r_v_cnt;
  rgb12_t r_rgb;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_frame_start;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .p_tick(w_p_tick)
  );

  // >= keeps the counters bounded even if they were ever disturbed past the end
  assign w_h_last    = (r_h_cnt >= H_LAST);
  assign w_v_last    = (r_v_cnt >= V_LAST);
  assign w_video_on  = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs_active = (r_h_cnt >= HS_START) && (r_h_cnt <= HS_END);
  assign w_vs_active = (r_v_cnt >= VS_START) && (r_v_cnt <= VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_rgb         <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_p_tick && w_h_last && w_v_last;
      if (w_p_tick) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + coord_t'(1);
        end else begin
          r_h_cnt <= r_h_cnt + coord_t'(1);
        end
        // Output stage samples the pre-advance position, hence the one-tick lag
        r_rgb   <= w_video_on ? rgb_in : '0;
        r_hsync <= w_hs_active ? SYNC_POL : ~SYNC_POL;
        r_vsync <= w_vs_active ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign x           = r_h_cnt;
  assign y           = r_v_cnt;
  assign video_on    = w_video_on;
  assign p_tick      = w_p_tick;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign rgb_out     = r_rgb;

endmodule
